// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end.
// Owns the fetch PC and keeps at most one request outstanding to a
// variable-latency instruction memory. It produces instrF/PCF/PCPlus4F for the
// Fetch->Decode register, which loads when validF && !stallF.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stallF            downstream cannot accept; hold the current output
//   redirect          restart fetch at redirectPC (bits [1:0] forced to 0)
//   redirectPC        redirect target
//   imem_req          one-cycle request strobe (combinational)
//   imem_addr         request address, always the internal pc
//   imem_rdata        response data, valid while imem_valid
//   imem_valid        response strobe
//   validF            fetch outputs hold a real instruction
//   instrF, PCF, PCPlus4F  registered fetch outputs
//
// state | meaning
// ------+----------------------------------------------------------
// ISSUE | request pc this cycle
// WAIT  | request outstanding; capture the response into the outputs
// HAVE  | outputs hold an instruction; issue the next fetch once it is consumed
// DROP  | a stale request is outstanding; discard its response
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic        validF,
  output logic [31:0] instrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F
);

  typedef enum logic [1:0] {ISSUE, WAIT, HAVE, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        valid_nxt;
  logic [31:0] instr_nxt, pcf_nxt, pcp4_nxt;

  // reset gating keeps the strobe low while the memory is also in reset
  assign imem_req  = !reset && !redirect &&
                     ((state == ISSUE) || ((state == HAVE) && !stallF));
  assign imem_addr = pc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = validF;
    instr_nxt = instrF;
    pcf_nxt   = PCF;
    pcp4_nxt  = PCPlus4F;
    if (redirect) begin
      pc_nxt    = {redirectPC[31:2], 2'b00};
      valid_nxt = 1'b0;
      instr_nxt = BUBBLE_INSTR;
      case (state)
        // a request still in flight must have its response swallowed
        WAIT:    state_nxt = imem_valid ? ISSUE : DROP;
        DROP:    state_nxt = DROP;
        default: state_nxt = ISSUE;
      endcase
    end else begin
      case (state)
        ISSUE: state_nxt = WAIT;
        WAIT: begin
          if (imem_valid) begin
            instr_nxt = imem_rdata;
            pcf_nxt   = pc;
            pcp4_nxt  = pc + 32'd4;
            valid_nxt = 1'b1;
            pc_nxt    = pc + 32'd4;
            state_nxt = HAVE;
          end
        end
        HAVE: begin
          // consumed this cycle; the next request is already on the bus
          if (!stallF) begin
            valid_nxt = 1'b0;
            instr_nxt = BUBBLE_INSTR;
            state_nxt = WAIT;
          end
        end
        DROP: begin
          if (imem_valid) state_nxt = ISSUE;
        end
        default: state_nxt = ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ISSUE;
      pc       <= RESET_PC;
      validF   <= 1'b0;
      instrF   <= BUBBLE_INSTR;
      PCF      <= 32'h0000_0000;
      PCPlus4F <= 32'h0000_0000;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      validF   <= valid_nxt;
      instrF   <= instr_nxt;
      PCF      <= pcf_nxt;
      PCPlus4F <= pcp4_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: table of per-cycle vectors against a small
// fixed-latency memory model, plus hand-written redirect/wrap sequences.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stallF = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPC = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        imem_valid = 1'b0;
  logic        validF;
  logic [31:0] instrF, PCF, PCPlus4F;

  localparam logic [31:0] XK = 32'hA5A5_A5A5;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stallF(stallF), .redirect(redirect),
    .redirectPC(redirectPC), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .validF(validF),
    .instrF(instrF), .PCF(PCF), .PCPlus4F(PCPlus4F)
  );

  always #5 clk = ~clk;

  // memory model: request seen at posedge of cycle t, response in cycle t+lat
  int          lat = 1;
  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] paddr = 0;

  always @(posedge clk) begin
    if (reset) pend = 0;
    else if (imem_req) begin
      pend  = 1;
      cnt   = lat;
      paddr = imem_addr;
    end
  end

  always @(negedge clk) begin
    imem_valid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = paddr ^ XK;
        pend = 0;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    @(negedge clk);
    #1;
    stallF = s;
    redirect = r;
    redirectPC = rpc;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic v, input logic [31:0] ins,
                         input logic [31:0] pcf, input logic [31:0] p4);
    chk({tag, " imem_req"}, {31'b0, imem_req}, {31'b0, req});
    chk({tag, " imem_addr"}, imem_addr, addr);
    chk({tag, " validF"}, {31'b0, validF}, {31'b0, v});
    chk({tag, " instrF"}, instrF, ins);
    chk({tag, " PCF"}, PCF, pcf);
    chk({tag, " PCPlus4F"}, PCPlus4F, p4);
  endtask

  typedef struct {
    logic        s;
    logic        r;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] ins;
    logic [31:0] pcf;
    logic [31:0] p4;
  } vec_t;

  vec_t vt[16];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // cycle-by-cycle expectations, L=1, data = addr ^ A5A5A5A5
    vt[0]  = '{0, 0, 0,     0, 32'h000, 0, 32'h0,         32'h000, 32'h000}; // response cycle
    vt[1]  = '{0, 0, 0,     1, 32'h004, 1, 32'hA5A5A5A5,  32'h000, 32'h004};
    vt[2]  = '{0, 0, 0,     0, 32'h004, 0, 32'h0,         32'h000, 32'h004};
    vt[3]  = '{1, 0, 0,     0, 32'h008, 1, 32'hA5A5A5A1,  32'h004, 32'h008}; // stall x5
    vt[4]  = '{1, 0, 0,     0, 32'h008, 1, 32'hA5A5A5A1,  32'h004, 32'h008};
    vt[5]  = '{1, 0, 0,     0, 32'h008, 1, 32'hA5A5A5A1,  32'h004, 32'h008};
    vt[6]  = '{1, 0, 0,     0, 32'h008, 1, 32'hA5A5A5A1,  32'h004, 32'h008};
    vt[7]  = '{1, 0, 0,     0, 32'h008, 1, 32'hA5A5A5A1,  32'h004, 32'h008};
    vt[8]  = '{0, 0, 0,     1, 32'h008, 1, 32'hA5A5A5A1,  32'h004, 32'h008}; // release
    vt[9]  = '{0, 0, 0,     0, 32'h008, 0, 32'h0,         32'h004, 32'h008};
    vt[10] = '{1, 1, 32'h200, 0, 32'h00C, 1, 32'hA5A5A5AD, 32'h008, 32'h00C}; // redirect+stall in HAVE
    vt[11] = '{0, 0, 0,     1, 32'h200, 0, 32'h0,         32'h008, 32'h00C};
    vt[12] = '{0, 1, 32'h303, 0, 32'h200, 0, 32'h0,       32'h008, 32'h00C}; // redirect with imem_valid
    vt[13] = '{0, 0, 0,     1, 32'h300, 0, 32'h0,         32'h008, 32'h00C};
    vt[14] = '{0, 0, 0,     0, 32'h300, 0, 32'h0,         32'h008, 32'h00C};
    vt[15] = '{1, 0, 0,     0, 32'h304, 1, 32'hA5A5A6A5,  32'h300, 32'h304};

    // reset: strobe held low, registers at reset values
    @(negedge clk); #2;
    chk_out("reset0", 0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
    @(negedge clk); #2;
    chk("reset1 imem_req", {31'b0, imem_req}, 32'h0);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    chk("cycle1 imem_req", {31'b0, imem_req}, 32'h1);
    chk("cycle1 imem_addr", imem_addr, 32'h0);

    for (int i = 0; i < 16; i++) begin
      step(vt[i].s, vt[i].r, vt[i].rpc);
      chk_out($sformatf("vec%0d", i), vt[i].req, vt[i].addr, vt[i].v,
              vt[i].ins, vt[i].pcf, vt[i].p4);
    end

    // L=3, redirect one cycle after the request: stale response dropped
    lat = 3;
    step(0, 0, 0);
    chk("l3 req", {31'b0, imem_req}, 32'h1);
    chk("l3 addr", imem_addr, 32'h304);
    step(0, 1, 32'h0000_0103);
    chk("l3 redir req", {31'b0, imem_req}, 32'h0);
    step(0, 0, 0);
    chk("drop1 req", {31'b0, imem_req}, 32'h0);
    chk("drop1 validF", {31'b0, validF}, 32'h0);
    chk("drop1 addr", imem_addr, 32'h100);
    step(0, 0, 0);
    chk("drop2 stale valid", {31'b0, imem_valid}, 32'h1);
    chk("drop2 req", {31'b0, imem_req}, 32'h0);
    chk("drop2 validF", {31'b0, validF}, 32'h0);
    step(0, 0, 0);
    chk("reissue req", {31'b0, imem_req}, 32'h1);
    chk("reissue addr", imem_addr, 32'h100);
    chk("reissue validF", {31'b0, validF}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      chk($sformatf("l3 wait%0d validF", i), {31'b0, validF}, 32'h0);
      chk($sformatf("l3 wait%0d req", i), {31'b0, imem_req}, 32'h0);
    end
    step(1, 0, 0);
    chk_out("l3 have", 0, 32'h104, 1, 32'hA5A5A4A5, 32'h100, 32'h104);

    // wrap: redirect to FFFFFFFF (low bits forced to 0)
    lat = 1;
    step(1, 1, 32'hFFFF_FFFF);
    chk("wrap redir validF", {31'b0, validF}, 32'h1);
    step(0, 0, 0);
    chk("wrap req", {31'b0, imem_req}, 32'h1);
    chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("wrap resp validF", {31'b0, validF}, 32'h0);
    step(1, 0, 0);
    chk_out("wrap have", 0, 32'h0, 1, 32'h5A5A5A59, 32'hFFFF_FFFC, 32'h0);
    step(0, 0, 0);
    chk("wrap next req", {31'b0, imem_req}, 32'h1);
    chk("wrap next addr", imem_addr, 32'h0);

    // reset with a request outstanding: strobe low, outputs cleared
    step(0, 0, 0);
    reset = 1'b1;
    #1;
    chk("midreset req", {31'b0, imem_req}, 32'h0);
    @(negedge clk); #2;
    chk_out("midreset", 0, 32'h0, 0, 32'h0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the five-stage pipeline. It owns the fetch PC, issues one request at a time to a variable-latency instruction memory, and produces `instrF`/`PCF`/`PCPlus4F` for the Fetch→Decode pipeline register. It honours stall and branch-redirect inputs from the hazard/branch logic and marks empty slots with `validF`. The Fetch→Decode register loads when `validF && !stallF`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset.
- `BUBBLE_INSTR`, 32'h0000_0000, instruction driven on `instrF` whenever `validF`=0.
- `clk`  in  1  rising-edge clock; the block's only clock.
- `reset`  in  1  synchronous, active-high reset, sampled on the `clk` rising edge.
- `stallF`  in  1  downstream cannot accept; hold the current output.
- `redirect`  in  1  taken branch or jump; restart fetch at `redirectPC`.
- `redirectPC`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `imem_req`  out  1  one-cycle request strobe.
- `imem_addr`  out  32  request address; equals the internal PC register.
- `imem_rdata`  in  32  response data; valid only while `imem_valid`=1.
- `imem_valid`  in  1  response strobe; at least 1 cycle after `imem_req`, and at most one response outstanding.
- `validF`  out  1  `instrF`/`PCF`/`PCPlus4F` hold a real instruction.
- `instrF`, `PCF`, `PCPlus4F`  out  32 each  registered fetch outputs.

## Operation
- State register encodings: ISSUE, WAIT, HAVE, DROP. The internal 32-bit `pc` register is the next fetch address.
- `imem_req` is combinational: `(ISSUE || (HAVE && !stallF)) && !redirect`. `imem_addr` = `pc` at all times.
- ISSUE: assert the request. Next state is WAIT. `imem_valid` is ignored in this state.
- WAIT: on `imem_valid`, capture `instrF`←`imem_rdata`, `PCF`←`pc`, `PCPlus4F`←`pc`+4 and `validF`←1. Also update `pc`←`pc`+4 and move to HAVE. `stallF` has no effect in WAIT; the response is always captured.
- HAVE: outputs hold while `stallF`=1. When `stallF`=0, the downstream register consumes the instruction this cycle and the next request issues in the same cycle. On the following edge, `validF`←0 and `instrF`←`BUBBLE_INSTR`, and the state moves to WAIT. `PCF`/`PCPlus4F` hold their old values.
- DROP: a stale request is outstanding. On `imem_valid`, discard `imem_rdata` and move to ISSUE.
- Redirect has priority over stall and over the normal transitions in every state:
  - On the edge: `pc`←{`redirectPC`[31:2],2'b00}, `validF`←0, `instrF`←`BUBBLE_INSTR`.
  - WAIT with no `imem_valid` this cycle: go to DROP.
  - WAIT with `imem_valid` this cycle: discard the data and go to ISSUE.
  - ISSUE or HAVE: go to ISSUE.
  - DROP: stay in DROP; only `pc` updates.
  - No request issues in a redirect cycle.
- Arithmetic is unsigned and modulo 2^32. `pc` 32'hFFFF_FFFC yields `PCPlus4F`=32'h0000_0000, and the next fetch is at 0.

## Timing
- Reset values, one cycle after `reset` is sampled high: state=ISSUE, `pc`=`RESET_PC`, `validF`=0, `instrF`=`BUBBLE_INSTR`, `PCF`=0, `PCPlus4F`=0.
  - `imem_req`=0 during any cycle in which `reset`=1.
  - `imem_req`=1 in the first cycle after reset deasserts.
- Reset mid-request abandons the outstanding request. The instruction memory shares `reset`, so no stale response arrives after reset.
- Memory latency L≥1 cycles. The request cycle is t, the response is at t+L, and `validF` rises at the edge ending cycle t+L.
- Steady-state throughput with no stall is one instruction per L+1 cycles.
- Redirect-to-request latency is 1 cycle from ISSUE/HAVE. From WAIT/DROP it is (remaining latency)+1 cycles.
- All outputs except `imem_req`/`imem_addr` are registered. `imem_req` depends combinationally on `stallF` and `redirect`.

## Test plan
- Reset, then L=1 memory returning `addr`^32'hA5A5_A5A5:
  - Request at `RESET_PC`=0 in cycle 1.
  - `validF`=1 with `instrF`=32'hA5A5_A5A5, `PCF`=0, `PCPlus4F`=4 after cycle 2.
  - Next request at `imem_addr`=4 in cycle 3.
- HAVE with `stallF`=1 held 5 cycles: outputs and `validF`=1 are unchanged and there is no `imem_req`. Releasing `stallF` issues the request at `pc`+4 in the same cycle.
- L=3 with `redirect`=1, `redirectPC`=32'h0000_0103 one cycle after the request:
  - State goes to DROP and the stale response is discarded.
  - The next `imem_req` carries `imem_addr`=32'h0000_0100.
  - `validF` stays 0 throughout.
- `redirect` in the same cycle as `imem_valid` in WAIT: the data is discarded, `validF`=0, and a request to the target issues the next cycle.
- `redirect` and `stallF` both high in HAVE: redirect wins, `validF`→0, `instrF`=`BUBBLE_INSTR`.
- Redirect to 32'hFFFF_FFFC: `PCF`=32'hFFFF_FFFC, `PCPlus4F`=0, and the next `imem_addr`=0.
